// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES UART frame receiver.
// The optional even-parity bit is enabled by defining AES_RX_PARITY_EN.
package aes_uart_pkg;

  localparam int AES_BLOCK_W      = 128;
  localparam int DEF_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/aes_uart_frame_rx_if.sv
// Block hand-off from the frame assembler to the AES core.
// valid/ready: the master holds block_data stable while block_valid is high;
// a transfer happens on every clock edge where block_valid && block_ready.
interface aes_uart_frame_rx_if
  import aes_uart_pkg::*;
#(
  parameter int W = AES_BLOCK_W
);

  logic [W-1:0] block_data;
  logic         block_valid;
  logic         block_ready;

  modport master (output block_data, output block_valid, input block_ready);
  modport slave  (input block_data, input block_valid, output block_ready);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, bit-timing FSM, one-cycle byte/err pulses.
// With AES_RX_PARITY_EN defined, an even-parity bit is checked between DATA and STOP.
module uart_rx_byte
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        err_o,
  output logic        busy_o,
  output uart_state_e state_o
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  sync_q;
  logic        prev_q;
  logic [2:0]  fill_q;
  uart_state_e state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        par_ok_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        err_q;
  logic        rx_s;

  assign rx_s = sync_q[1];

  // fill_q marks when prev_q holds a real pin sample, so a line held low
  // through reset release is not mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      fill_q   <= 3'b000;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_ok_q <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      fill_q  <= {fill_q[1:0], 1'b1};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fill_q[2] && prev_q && !rx_s) begin
            cnt_q   <= HALF_LOAD;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (!rx_s) begin
            cnt_q    <= BIT_LAST;
            bit_q    <= 3'd0;
            par_ok_q <= 1'b1;
            state_q  <= DATA;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            cnt_q   <= BIT_LAST;
            if (bit_q == 3'd7) begin
`ifdef AES_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
        PARITY: begin
`ifdef AES_RX_PARITY_EN
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            par_ok_q <= (rx_s == ^shift_q);
            cnt_q    <= BIT_LAST;
            state_q  <= STOP;
          end
`else
          state_q <= IDLE;
`endif
        end
        STOP: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            if (rx_s && par_ok_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_o       = data_q;
  assign byte_valid_o = valid_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != IDLE);
  assign state_o      = state_q;

endmodule

// File: rtl/aes_uart_frame_rx.sv
// UART frame receiver: packs FRAME_BYTES bytes into one AES block, valid/ready hand-off.
// Optional even parity via AES_RX_PARITY_EN (handled inside uart_rx_byte).
module aes_uart_frame_rx
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FRAME_BYTES  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx,
  aes_uart_frame_rx_if.master        blk,
  output logic                       frames_received,
  output logic                       rx_busy,
  output logic [3:0]                 byte_count,
  output logic                       framing_err,
  output logic                       overflow,
  output uart_state_e                rx_state_o
);

  localparam int         BW   = 8 * FRAME_BYTES;
  localparam logic [3:0] LAST = 4'(FRAME_BYTES - 1);

  logic [7:0]    rx_byte;
  logic          rx_byte_valid;
  logic [BW-1:0] asm_q;
  logic [BW-1:0] asm_d;
  logic [BW-1:0] data_q;
  logic          valid_q;
  logic          frame_q;
  logic          ovf_q;
  logic [3:0]    cnt_q;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (uart_rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .err_o        (framing_err),
    .busy_o       (rx_busy),
    .state_o      (rx_state_o)
  );

  assign asm_d = {asm_q[BW-9:0], rx_byte};

  // The handshake clear comes first so a same-cycle frame load overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      frame_q <= 1'b0;
      if (valid_q && blk.block_ready) begin
        valid_q <= 1'b0;
      end
      if (rx_byte_valid) begin
        asm_q <= asm_d;
        if (cnt_q == LAST) begin
          cnt_q <= '0;
          if (!valid_q || blk.block_ready) begin
            data_q  <= asm_d;
            valid_q <= 1'b1;
            frame_q <= 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

  assign blk.block_data  = data_q;
  assign blk.block_valid = valid_q;
  assign frames_received = frame_q;
  assign byte_count      = cnt_q;
  assign overflow        = ovf_q;

endmodule
